// File: rtl/ro_count_reader.sv
// ro_count_reader: measures a ring-oscillator counter delta over a fixed window of clk cycles
module ro_count_reader #(
  parameter int WIDTH       = 16,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_RETRY   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic [WIDTH-1:0] ro_count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] delta,
  output logic             read_err
);
  localparam int WW = $clog2(WINDOW);
  localparam int RW = $clog2(MAX_RETRY + 1);
  typedef enum logic [2:0] {IDLE, CAP_START, WAIT, CAP_END, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_dly_q, start_val_q, end_val_q, delta_q, samp;
  logic [WW-1:0]    win_q;
  logic [RW-1:0]    retry_q;
  logic             busy_q, done_q, err_q, stable, force_cap, cap;
  assign samp      = sync_q[SYNC_STAGES-1];
  assign stable    = samp == sync_dly_q;
  // the last tolerated unstable cycle captures whatever is there
  assign force_cap = !stable && (retry_q == RW'(MAX_RETRY - 1));
  assign cap       = stable || force_cap;
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_dly_q <= '0;
    end else begin
      sync_q[0] <= ro_count;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_dly_q <= samp;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      delta_q     <= '0;
      start_val_q <= '0;
      end_val_q   <= '0;
      win_q       <= '0;
      retry_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= CAP_START;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
          retry_q <= '0;
        end
        CAP_START: if (cap) begin
          start_val_q <= samp;
          win_q       <= WW'(WINDOW - 1);
          err_q       <= err_q | force_cap;
          state_q     <= WAIT;
        end else retry_q <= retry_q + 1'b1;
        WAIT: if (win_q == '0) begin
          state_q <= CAP_END;
          retry_q <= '0;
        end else win_q <= win_q - 1'b1;
        CAP_END: if (cap) begin
          end_val_q <= samp;
          delta_q   <= samp - start_val_q;
          done_q    <= 1'b1;
          busy_q    <= continuous;
          err_q     <= err_q | force_cap;
          state_q   <= DONE;
        end else retry_q <= retry_q + 1'b1;
        DONE: if (continuous) begin
          start_val_q <= end_val_q;
          win_q       <= WW'(WINDOW - 1);
          busy_q      <= 1'b1;
          state_q     <= WAIT;
        end else begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign delta    = delta_q;
  assign read_err = err_q;
endmodule

// File: tb/tb_ro_count_reader.sv
// tb_ro_count_reader: randomized bench with an edge-indexed reference model of the counter reader
module tb_ro_count_reader;
  localparam int W = 64, S = 2, MR = 8, N = 8192;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, continuous = 1'b0;
  logic [15:0] ro_count = '0;
  logic        busy, done, read_err;
  logic [15:0] delta;
  logic [15:0] ro_at [N];
  int          edge_n = 0, n_chk = 0, n_err = 0, last_ts = 0;
  int          obs[$];
  logic [15:0] delta_m = '0;
  logic        err_m = 1'b0;

  ro_count_reader #(.WIDTH(16), .WINDOW(W), .SYNC_STAGES(S), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .ro_count(ro_count),
    .busy(busy), .done(done), .delta(delta), .read_err(read_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ro_at[k] is the value the DUT samples at posedge number k
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    ro_count = ro_at[edge_n+1];
  endtask

  task automatic gen(input int mode, input logic [15:0] base, input int p, input int thr);
    logic [15:0] x;
    x = base;
    for (int k = 1; k <= 400; k++) begin
      case (mode)
        0: ro_at[edge_n+k] = base;
        1: begin ro_at[edge_n+k] = x; if (k % p == 0) x++; end
        2: ro_at[edge_n+k] = (k % 2 == 1) ? 16'hFFFF : 16'h0000;
        default: begin
          x += 16'(($urandom % p) == 0);
          ro_at[edge_n+k] = ($urandom_range(0, 7) < thr) ? x ^ 16'($urandom) : x;
        end
      endcase
    end
    ro_count = ro_at[edge_n+1];
  endtask

  // A capture decided at edge e sees the value sampled S edges earlier and the one before it.
  function automatic int capture(input int e, output logic [15:0] v, output logic f);
    v = '0;
    f = 1'b0;
    for (int k = 0; k < MR; k++) begin
      logic st;
      st = ro_at[e+k-S] == ro_at[e+k-S-1];
      if (st || k == MR - 1) begin
        v = ro_at[e+k-S];
        f = !st;
        return e + k;
      end
    end
    return e;
  endfunction

  task automatic run(input logic cont, input int nmeas, input logic poke, input string tag);
    int ts, c, ce, fin, drop_e, poke_e, j, fj;
    logic [15:0] sv, ev;
    logic f, done_e;
    int dn_e[$], f_e[$];
    logic [15:0] dn_v[$];
    ts = edge_n + 1;
    last_ts = ts;
    drop_e = -1;
    c = capture(ts + 1, sv, f);
    if (f) f_e.push_back(c);
    poke_e = c + W / 2;
    ce = c + W + 1;
    for (int i = 0; i < nmeas; i++) begin
      if (i == nmeas - 1) drop_e = ce - W / 2;
      c = capture(ce, ev, f);
      if (f) f_e.push_back(c);
      dn_e.push_back(c);
      dn_v.push_back(ev - sv);
      sv = ev;
      ce = c + W + 2;
    end
    fin = dn_e[dn_e.size()-1];
    obs.delete();
    j = 0;
    fj = 0;
    start = 1'b1;
    continuous = cont;
    for (int e = ts; e <= fin + 3; e++) begin
      tick();
      start = poke && (edge_n == poke_e);
      if (edge_n == drop_e) continuous = 1'b0;
      done_e = 1'b0;
      if (j < dn_e.size() && edge_n == dn_e[j]) begin
        done_e = 1'b1;
        delta_m = dn_v[j];
        j++;
      end
      if (edge_n == ts) err_m = 1'b0;
      if (fj < f_e.size() && edge_n == f_e[fj]) begin
        err_m = 1'b1;
        fj++;
      end
      if (done) obs.push_back(edge_n);
      chk({tag, "_busy"}, busy, (edge_n >= ts && edge_n < fin));
      chk({tag, "_done"}, done, done_e);
      chk({tag, "_delta"}, delta, delta_m);
      chk({tag, "_err"}, read_err, err_m);
    end
    start = 1'b0;
    continuous = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) ro_at[i] = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_delta", delta, 0);
    chk("rst_err", read_err, 0);
    rst = 1'b1;

    gen(0, 16'h1234, 1, 0);
    repeat (4) tick();
    run(1'b0, 1, 1'b0, "static");
    chk("static_ndone", obs.size(), 1);
    if (obs.size() == 1) chk("static_lat", obs[0] - last_ts, W + 2);
    chk("static_zero", delta, 0);

    gen(1, 16'($urandom), 4, 0);
    repeat (4) tick();
    run(1'b0, 1, 1'b0, "ramp");
    chk("ramp_range", (delta >= 15 && delta <= 17), 1);

    gen(1, 16'hFFF0, 2, 0);
    repeat (4) tick();
    run(1'b0, 1, 1'b0, "wrap");
    chk("wrap_range", (delta >= 31 && delta <= 33), 1);

    gen(2, 16'h0000, 1, 0);
    repeat (4) tick();
    run(1'b0, 1, 1'b0, "unstable");
    chk("unst_err", read_err, 1);
    chk("unst_ndone", obs.size(), 1);
    if (obs.size() == 1) chk("unst_lat", obs[0] - last_ts, W + 2 + 2 * (MR - 1));
    gen(0, 16'h5A5A, 1, 0);
    repeat (4) tick();
    chk("err_sticky", read_err, 1);
    run(1'b0, 1, 1'b0, "reclr");
    chk("err_clr", read_err, 0);

    gen(1, 16'($urandom), 3, 0);
    repeat (4) tick();
    run(1'b1, 3, 1'b1, "cont");
    chk("cont_ndone", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("cont_gap1", obs[1] - obs[0], W + 2);
      chk("cont_gap2", obs[2] - obs[1], W + 2);
    end

    for (int r = 0; r < 6; r++) begin
      logic cont;
      cont = 1'($urandom % 2);
      gen(3, 16'($urandom), $urandom_range(1, 4), $urandom_range(0, 7));
      repeat (4) tick();
      run(cont, cont ? 2 : 1, 1'b0, "rand");
    end

    gen(0, 16'h0BEE, 1, 0);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    start = 1'b1;
    tick();
    rst = 1'b1;
    start = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_delta", delta, 0);
    chk("mrst_err", read_err, 0);
    for (int i = 0; i < W + 10; i++) begin
      tick();
      chk("mrst_nodone", done, 0);
      chk("mrst_idle", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
